// File: rtl/fetch_unit_pkg.sv
// Shared ISA constants, FSM state encoding and immediate helpers for the fetch stage.
package fetch_unit_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  // Full instruction word injected into decode whenever fetch is not running.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DUMP   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext11(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Control-flow target calculation: produces the redirect target and whether
// the current instruction redirects at all. The caller falls back to PC+2.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [10:0] imm11,
  input  logic [7:0]  imm8,
  input  logic [15:0] pc_plus2,
  input  logic [15:0] rs_data,
  output logic [15:0] target_pc,
  output logic        taken
);

  logic [15:0] branch_target;
  logic [15:0] jump_target;
  logic [15:0] reg_target;

  assign branch_target = pc_plus2 + sext8(imm8);
  assign jump_target   = pc_plus2 + sext11(imm11);
  assign reg_target    = rs_data + sext8(imm8);

  // Decode the opcode into a target and a taken decision; branches test Rs.
  always_comb begin
    target_pc = branch_target;
    taken     = 1'b0;
    case (opcode)
      OP_J, OP_JAL: begin
        target_pc = jump_target;
        taken     = 1'b1;
      end
      OP_JR, OP_JALR: begin
        target_pc = reg_target;
        taken     = 1'b1;
      end
      OP_BEQZ: taken = (rs_data == 16'h0000);
      OP_BNEZ: taken = (rs_data != 16'h0000);
      OP_BLTZ: taken = rs_data[15];
      OP_BGEZ: taken = ~rs_data[15];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_16b.sv
// Generic 16-bit register with write enable and synchronous reset to a chosen value.
module reg_16b #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeEn,
  input  logic [15:0] data_in,
  output logic [15:0] data_out
);

  logic [15:0] data_q;
  logic [15:0] data_d;

  // Hold the stored value unless a write is requested.
  always_comb begin
    data_d = data_q;
    if (writeEn) begin
      data_d = data_in;
    end
  end

  // Storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, selects the next PC, and sequences
// HALT into a single memory-dump pulse followed by a permanent halted state.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [15:0] imem_data,
  input  logic [15:0] rs_data,
  output logic [15:0] imem_addr,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        createdump,
  output logic        halted,
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic         createdump_q, createdump_d;
  logic         halted_q, halted_d;
  logic         err_q, err_d;

  logic [15:0]  pc_q;
  logic [15:0]  target_pc;
  logic         taken;
  logic [15:0]  next_pc;
  logic [4:0]   opcode;
  logic         in_run;
  logic         is_halt;
  logic         pc_write_en;

  // Outside RUN decode sees a NOP so nothing downstream acts on stale words.
  assign in_run    = (state_q == ST_RUN);
  assign instr     = in_run ? imem_data : NOP_INSTR;
  assign opcode    = instr[15:11];
  assign is_halt   = (opcode == OP_HALT);
  assign imem_addr = pc_q;
  assign pc_plus2  = pc_q + 16'd2;
  assign next_pc   = taken ? target_pc : pc_plus2;

  // A stalled HALT is not consumed; a consumed HALT freezes the PC.
  assign pc_write_en = in_run & ~stall & ~is_halt;

  next_pc_calc u_next_pc_calc (
    .opcode    (opcode),
    .imm11     (instr[10:0]),
    .imm8      (instr[7:0]),
    .pc_plus2  (pc_plus2),
    .rs_data   (rs_data),
    .target_pc (target_pc),
    .taken     (taken)
  );

  reg_16b #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .writeEn  (pc_write_en),
    .data_in  (next_pc),
    .data_out (pc_q)
  );

  // Next-state logic for HALT sequencing plus the sticky misalignment flag.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (is_halt) begin
            state_d = ST_DUMP;
          end else if (next_pc[0]) begin
            err_d = 1'b1;
          end
        end
      end
      ST_DUMP:   state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
    createdump_d = (state_d == ST_DUMP);
    halted_d     = (state_d == ST_HALTED);
  end

  // State and registered status outputs; reset cancels any pending dump.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      createdump_q <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      createdump_q <= createdump_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
    end
  end

  assign createdump = createdump_q;
  assign halted     = halted_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetch vectors plus
// hand-written HALT / reset-during-dump sequences, checked through a scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [15:0] imem_data;
  logic [15:0] rs_data;
  logic [15:0] imem_addr;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        createdump;
  logic        halted;
  logic        err;

  fetch_unit #(
    .RESET_PC (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .imem_data  (imem_data),
    .rs_data    (rs_data),
    .imem_addr  (imem_addr),
    .instr      (instr),
    .pc_plus2   (pc_plus2),
    .createdump (createdump),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic        cd;
    logic        hl;
    logic        er;
    logic [15:0] ins;
  } exp_t;

  typedef struct {
    string       name;
    logic        stall;
    logic [15:0] instr;
    logic [15:0] rs;
    logic [15:0] exp_pc;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[20];
  int   checks = 0;
  int   errors = 0;

  localparam logic [15:0] NOP  = 16'h0800;
  localparam logic [15:0] HALT = 16'h0000;

  task automatic cmp16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show after the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [15:0] ins,
                               input logic [15:0] rs, input string nm, input logic [15:0] epc,
                               input logic ecd, input logic ehl, input logic eer, input logic erun);
    exp_t e;
    rst       = r;
    stall     = s;
    imem_data = ins;
    rs_data   = rs;
    e.name = nm;
    e.pc   = epc;
    e.cd   = ecd;
    e.hl   = ehl;
    e.er   = eer;
    e.ins  = erun ? ins : NOP;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      cmp16({e.name, ".pc"},       imem_addr,  e.pc);
      cmp16({e.name, ".pc_plus2"}, pc_plus2,   e.pc + 16'd2);
      cmp16({e.name, ".instr"},    instr,      e.ins);
      cmp1 ({e.name, ".dump"},     createdump, e.cd);
      cmp1 ({e.name, ".halted"},   halted,     e.hl);
      cmp1 ({e.name, ".err"},      err,        e.er);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [15:0] ins,
                      input logic [15:0] rs, input string nm, input logic [15:0] epc,
                      input logic ecd, input logic ehl, input logic eer, input logic erun);
    applyStimulus(r, s, ins, rs, nm, epc, ecd, ehl, eer, erun);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    vecs[0]  = '{"nop0",       1'b0, NOP,      16'h0000, 16'h0002, 1'b0};
    vecs[1]  = '{"nop1",       1'b0, NOP,      16'h0000, 16'h0004, 1'b0};
    vecs[2]  = '{"nop2",       1'b0, NOP,      16'h0000, 16'h0006, 1'b0};
    vecs[3]  = '{"jr_to_10a",  1'b0, 16'h2800, 16'h0010, 16'h0010, 1'b0};
    vecs[4]  = '{"beqz_taken", 1'b0, 16'h6006, 16'h0000, 16'h0018, 1'b0};
    vecs[5]  = '{"jr_to_10b",  1'b0, 16'h2800, 16'h0010, 16'h0010, 1'b0};
    vecs[6]  = '{"beqz_not",   1'b0, 16'h6006, 16'h0005, 16'h0012, 1'b0};
    vecs[7]  = '{"jr_to_10c",  1'b0, 16'h2800, 16'h0010, 16'h0010, 1'b0};
    vecs[8]  = '{"bltz_back",  1'b0, 16'h70F8, 16'h8000, 16'h000A, 1'b0};
    vecs[9]  = '{"jr_to_20",   1'b0, 16'h2800, 16'h0020, 16'h0020, 1'b0};
    vecs[10] = '{"j_back4",    1'b0, 16'h27FC, 16'h0000, 16'h001E, 1'b0};
    vecs[11] = '{"stall_hold", 1'b1, NOP,      16'h0000, 16'h001E, 1'b0};
    vecs[12] = '{"bnez_not",   1'b0, 16'h6804, 16'h0000, 16'h0020, 1'b0};
    vecs[13] = '{"bgez_taken", 1'b0, 16'h7804, 16'h0001, 16'h0026, 1'b0};
    vecs[14] = '{"jal_fwd",    1'b0, 16'h3010, 16'h0000, 16'h0038, 1'b0};
    vecs[15] = '{"jalr",       1'b0, 16'h3802, 16'h0100, 16'h0102, 1'b0};
    vecs[16] = '{"jr_to_fffe", 1'b0, 16'h2800, 16'hFFFE, 16'hFFFE, 1'b0};
    vecs[17] = '{"wrap_nop",   1'b0, NOP,      16'h0000, 16'h0000, 1'b0};
    vecs[18] = '{"jr_odd",     1'b0, 16'h2803, 16'h1234, 16'h1237, 1'b1};
    vecs[19] = '{"err_sticky", 1'b0, NOP,      16'h0000, 16'h1239, 1'b1};

    rst       = 1'b1;
    stall     = 1'b0;
    imem_data = NOP;
    rs_data   = 16'h0000;
    @(posedge clk);
    #1;

    $display("[TB] reset and fetch vectors");
    step(1'b1, 1'b0, NOP, 16'h0000, "reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, vecs[i].stall, vecs[i].instr, vecs[i].rs, vecs[i].name,
           vecs[i].exp_pc, 1'b0, 1'b0, vecs[i].exp_err, 1'b1);
    end

    $display("[TB] HALT with stall, dump pulse, halted hold");
    step(1'b1, 1'b0, NOP,      16'h0000, "halt_rst",    16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h2800, 16'h0040, "to_40",       16'h0040, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, HALT,     16'h0000, "halt_stall1", 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, HALT,     16'h0000, "halt_stall2", 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, HALT,     16'h0000, "halt_dump",   16'h0040, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h2803, 16'h1235, "halted0",     16'h0040, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h27FC, 16'h0000, "halted_hold", 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] reset during DUMP");
    step(1'b1, 1'b0, NOP,  16'h0000, "rd_rst",    16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, HALT, 16'h0000, "rd_dump",   16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, NOP,  16'h0000, "rd_reset",  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, NOP,  16'h0000, "rd_after1", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, NOP,  16'h0000, "rd_after2", 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
